// File: rtl/issue_scoreboard.sv
// Issue-stage hazard scoreboard: RAW/WAW stalls on scalar/vector pending bits, in-flight cap, halt/sync drain FSM.
// Optional SCOREBOARD_BYPASS_EN lets a same-cycle writeback unblock a dependent issue.
module issue_scoreboard #(
  parameter  int NREG         = 32,
  parameter  int MAX_INFLIGHT = 8,
  localparam int IDXW         = $clog2(NREG),
  localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic            r_read1,
  input  logic            r_read2,
  input  logic [IDXW-1:0] scalar_read_register1,
  input  logic [IDXW-1:0] scalar_read_register2,
  input  logic            v_read1,
  input  logic            v_read2,
  input  logic [IDXW-1:0] vector_read_register1,
  input  logic [IDXW-1:0] vector_read_register2,
  input  logic            register_wr_en,
  input  logic [IDXW-1:0] scalar_write_register,
  input  logic            vector_wr_en,
  input  logic [IDXW-1:0] vector_write_register,
  input  logic            halt,
  input  logic            synch_req,
  input  logic            wb_scalar_valid,
  input  logic [IDXW-1:0] wb_scalar_reg,
  input  logic            wb_vector_valid,
  input  logic [IDXW-1:0] wb_vector_reg,
  output logic [CW-1:0]   inflight,
  output logic            synch_ack,
  output logic            halted,
  output logic            sb_error
);

  localparam logic [2:0] S_RUN     = 3'd0;
  localparam logic [2:0] S_DRAIN_H = 3'd1;
  localparam logic [2:0] S_HALTED  = 3'd2;
  localparam logic [2:0] S_DRAIN_S = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;

  logic [2:0]      r_state, w_state_nxt;
  logic [NREG-1:0] r_spend, r_vpend;
  logic [CW-1:0]   r_inflight;
  logic            r_sb_error;

  logic [NREG-1:0] w_sclr, w_vclr, w_sset, w_vset, w_schk, w_vchk;
  logic            w_raw, w_waw, w_cap_ok, w_accept;
  logic            w_s_good, w_v_good, w_s_bad, w_v_bad;
  int              w_cap_sum, w_cnt_nxt;

  assign w_sclr = wb_scalar_valid ? (NREG'(1) << wb_scalar_reg) : '0;
  assign w_vclr = wb_vector_valid ? (NREG'(1) << wb_vector_reg) : '0;

`ifdef SCOREBOARD_BYPASS_EN
  // A committing writeback hides its pending bit from this cycle's hazard checks.
  assign w_schk = r_spend & ~w_sclr;
  assign w_vchk = r_vpend & ~w_vclr;
`else
  assign w_schk = r_spend;
  assign w_vchk = r_vpend;
`endif

  assign w_raw = (r_read1 & w_schk[scalar_read_register1]) |
                 (r_read2 & w_schk[scalar_read_register2]) |
                 (v_read1 & w_vchk[vector_read_register1]) |
                 (v_read2 & w_vchk[vector_read_register2]);
  assign w_waw = (register_wr_en & w_schk[scalar_write_register]) |
                 (vector_wr_en   & w_vchk[vector_write_register]);

  assign w_cap_sum = int'(r_inflight) + int'(register_wr_en) + int'(vector_wr_en)
                   - int'(wb_scalar_valid) - int'(wb_vector_valid);
  assign w_cap_ok  = (w_cap_sum <= MAX_INFLIGHT);

  assign issue_ready = (r_state == S_RUN) & ~w_raw & ~w_waw & w_cap_ok;
  assign w_accept    = issue_valid & issue_ready;

  assign w_sset = (w_accept & register_wr_en) ? (NREG'(1) << scalar_write_register) : '0;
  assign w_vset = (w_accept & vector_wr_en)   ? (NREG'(1) << vector_write_register) : '0;

  // Only writebacks that hit a pending bit retire an in-flight write.
  assign w_s_good = wb_scalar_valid &  r_spend[wb_scalar_reg];
  assign w_s_bad  = wb_scalar_valid & ~r_spend[wb_scalar_reg];
  assign w_v_good = wb_vector_valid &  r_vpend[wb_vector_reg];
  assign w_v_bad  = wb_vector_valid & ~r_vpend[wb_vector_reg];

  assign w_cnt_nxt = int'(r_inflight) + int'(w_accept & register_wr_en) + int'(w_accept & vector_wr_en)
                   - int'(w_s_good) - int'(w_v_good);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_accept & halt)           w_state_nxt = S_DRAIN_H;
        else if (w_accept & synch_req) w_state_nxt = S_DRAIN_S;
      end
      S_DRAIN_H: if (r_inflight == '0) w_state_nxt = S_HALTED;
      S_HALTED:  w_state_nxt = S_HALTED;
      S_DRAIN_S: if (r_inflight == '0) w_state_nxt = S_ACK;
      S_ACK:     w_state_nxt = S_RUN;
      default:   w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_spend    <= '0;
      r_vpend    <= '0;
      r_inflight <= '0;
      r_sb_error <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_spend    <= (r_spend & ~w_sclr) | w_sset;
      r_vpend    <= (r_vpend & ~w_vclr) | w_vset;
      r_inflight <= CW'(w_cnt_nxt);
      if (w_s_bad | w_v_bad) r_sb_error <= 1'b1;
    end
  end

  assign inflight  = r_inflight;
  assign synch_ack = (r_state == S_ACK);
  assign halted    = (r_state == S_HALTED);
  assign sb_error  = r_sb_error;

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Issue-stage hazard controller between the decoder's control bus and the scalar/vector register files. It tracks pending writes to every scalar and vector register and stalls issue on RAW and WAW hazards. It bounds the number of in-flight writes. It sequences `halt` and `synch_req` by draining all outstanding writebacks before halting or acknowledging the sync.

## Interface
Parameters:
- `NREG`, 32: registers per file; register index width is `$clog2(NREG)`, 5 at default.
- `MAX_INFLIGHT`, 8: maximum outstanding register writes across both files.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `issue_valid`  in  1: decoder presents a decoded instruction.
- `issue_ready`  out  1: instruction is accepted this cycle. Combinational.
- `r_read1`, `r_read2`  in  1 each: scalar source operand used.
- `scalar_read_register1`, `scalar_read_register2`  in  5 each: scalar source indices.
- `v_read1`, `v_read2`  in  1 each: vector source operand used.
- `vector_read_register1`, `vector_read_register2`  in  5 each: vector source indices.
- `register_wr_en`  in  1: instruction writes a scalar register.
- `scalar_write_register`  in  5: scalar destination index.
- `vector_wr_en`  in  1: instruction writes a vector register.
- `vector_write_register`  in  5: vector destination index.
- `halt`  in  1: instruction is a halt.
- `synch_req`  in  1: instruction is a sync.
- `wb_scalar_valid`  in  1: scalar writeback is committing this cycle.
- `wb_scalar_reg`  in  5: scalar writeback index.
- `wb_vector_valid`  in  1: vector writeback is committing this cycle.
- `wb_vector_reg`  in  5: vector writeback index.
- `inflight`  out  `$clog2(MAX_INFLIGHT+1)`: outstanding write count. Reset value 0.
- `synch_ack`  out  1: one-cycle pulse when a sync has drained. Reset value 0.
- `halted`  out  1: machine halted. Sticky until reset. Reset value 0.
- `sb_error`  out  1: sticky flag set by a writeback to a non-pending register. Reset value 0.

## Operation
- State: two `NREG`-bit pending vectors, `spend` and `vpend`, plus the `inflight` counter and an FSM. All reset to 0 / RUN.
- Accept is defined as `issue_valid & issue_ready`.
- `issue_ready` is 1 only when all of the following hold:
  - state is RUN;
  - no used source is pending (`r_readN` gates `spend[scalar_read_registerN]`; `v_readN` gates `vpend[vector_read_registerN]`);
  - no enabled destination is pending (WAW stall);
  - `inflight + register_wr_en + vector_wr_en - wb_scalar_valid - wb_vector_valid <= MAX_INFLIGHT`.
- On accept:
  - set `spend[scalar_write_register]` if `register_wr_en`;
  - set `vpend[vector_write_register]` if `vector_wr_en`.
- On writeback valid:
  - clear the indexed pending bit;
  - if that bit was already clear, leave it clear, do not decrement `inflight`, and set `sb_error`.
- Same-register set and clear in the same cycle: set wins, so the bit stays 1. The counter still applies both the +1 and the -1.
- `inflight` next value is `inflight + sets - valid clears`, computed as a signed sum that never wraps. Underflow cannot occur because invalid clears are not counted.
- Register 0 has no special treatment.
- FSM:
  - RUN: an accepted `halt` goes to DRAIN_H. An accepted `synch_req` goes to DRAIN_S. Halt/sync instructions carry no write.
  - DRAIN_H: `issue_ready=0`. Go to HALTED on the first cycle in which `inflight==0`.
  - HALTED: `halted=1`, `issue_ready=0`. Writebacks still update pending bits and `sb_error`. Leave only by reset.
  - DRAIN_S: `issue_ready=0`. When `inflight==0`, go to ACK.
  - ACK: `synch_ack=1` for exactly one cycle, `issue_ready=0`, then RUN.
- If `halt` and `synch_req` are both set on an accepted instruction, halt wins.
- Reset mid-drain: all pending bits, the counter and the flags clear, and the FSM returns to RUN immediately. Writebacks arriving after reset are flagged as `sb_error`.

## Timing
- `issue_ready` is a same-cycle combinational function of the inputs and the registered state.
- Pending bits and `inflight` update at the edge after accept or writeback.
- Without bypass: a source stalled on register R becomes ready the cycle after R's writeback.
- Drain latency: the FSM leaves DRAIN_* the cycle after the edge at which `inflight` becomes 0. `synch_ack` asserts in the following cycle. RUN resumes one cycle after that.

## Configuration
- `SCOREBOARD_BYPASS_EN`
  - Defined: a same-cycle `wb_*_valid` to register R masks R's pending bit in both the RAW and WAW checks, so a dependent instruction issues in the writeback cycle. A WAW to R in that cycle re-sets the bit.
  - Undefined: hazard checks use registered pending bits only, adding one stall cycle.

## Test plan
- Scalar RAW:
  - stimulus: issue write s3, then issue a read of s3; writeback s3 4 cycles later;
  - without bypass: `issue_ready=0` until the cycle after writeback;
  - with bypass: `issue_ready=1` in the writeback cycle.
- WAW and same-cycle set/clear:
  - pending v5 blocks a second write to v5 until v5's writeback;
  - an accept writing v5 in the same cycle as v5's writeback (bypass) leaves `vpend[5]=1` and `inflight` unchanged.
- Capacity:
  - issue 8 writes to distinct registers without writeback; `inflight=8` and a ninth write stalls;
  - a ninth write coinciding with one writeback is accepted.
- Halt drain:
  - 3 writes in flight, accept `halt`; `issue_ready=0`;
  - after the third writeback, `halted=1` one cycle later and stays 1 under further `issue_valid`.
- Sync:
  - 2 writes in flight, accept `synch_req`;
  - `synch_ack` is a single-cycle pulse after drain, then `issue_ready` returns;
  - with 0 in flight, `synch_ack` appears 2 cycles after accept.
- Error and reset:
  - writeback of non-pending s7: `sb_error=1`, `inflight` unchanged;
  - assert `rst_n=0` during DRAIN_H: all outputs return to reset values asynchronously.
